// File: rtl/jedro_1_mem_responder.sv
// Memory-side responder for the jedro_1 req/gnt/rvalid bus: word RAM, configurable
// grant wait and response latency, at most one outstanding transfer.
module jedro_1_mem_responder #(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned GNT_WAIT   = 0,
  parameter int unsigned RVALID_LAT = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned AW         = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] END_ADDR   = 33'(BASE_ADDR) + 33'(4 * MEM_WORDS);
  localparam logic [3:0]  GNT_WAIT_W = 4'(GNT_WAIT);
  localparam logic [3:0]  LAT_INIT   = 4'(RVALID_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT_WAIT,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [3:0]  lat_q, lat_d;
  logic [31:0] cap_data_q, cap_data_d;
  logic        cap_err_q, cap_err_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [MEM_WORDS];

  logic          eligible_c;
  logic          gnt_c;
  logic          addr_err_c;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word_c;

  // A slot frees up in the very cycle its response is on the bus.
  assign eligible_c = (state_q != RESP) || rvalid_q;
  assign gnt_c      = !rst_i && req_i && eligible_c && (wait_q == GNT_WAIT_W);
  assign addr_err_c = (addr_i[1:0] != 2'b00) || (addr_i < BASE_ADDR) ||
                      (33'(addr_i) >= END_ADDR);
  assign word_idx   = AW'((addr_i - BASE_ADDR) >> 2);
  assign rd_word_c  = mem[word_idx];

  assign gnt_o    = gnt_c;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

  // Next-state, wait/latency counters and response payload.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    lat_d      = lat_q;
    cap_data_d = cap_data_q;
    cap_err_d  = cap_err_q;
    rvalid_d   = 1'b0;
    rdata_d    = '0;
    err_d      = 1'b0;

    if (gnt_c || !req_i) begin
      wait_d = '0;
    end else if (eligible_c) begin
      wait_d = wait_q + 4'd1;
    end

    if (gnt_c) begin
      lat_d      = LAT_INIT;
      cap_err_d  = addr_err_c;
      cap_data_d = (we_i || addr_err_c) ? '0 : rd_word_c;
    end

    unique case (state_q)
      IDLE: begin
        if (gnt_c)      state_d = RESP;
        else if (req_i) state_d = GRANT_WAIT;
      end
      GRANT_WAIT: begin
        if (gnt_c)       state_d = RESP;
        else if (!req_i) state_d = IDLE;
      end
      RESP: begin
        if (gnt_c)         state_d = RESP;
        else if (rvalid_q) state_d = req_i ? GRANT_WAIT : IDLE;
        else               lat_d   = lat_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase

    rvalid_d = (state_d == RESP) && (lat_d == 4'd0);
    if (rvalid_d) begin
      rdata_d = cap_data_d;
      err_d   = cap_err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      lat_q      <= '0;
      cap_data_q <= '0;
      cap_err_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      lat_q      <= lat_d;
      cap_data_q <= cap_data_d;
      cap_err_q  <= cap_err_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // RAM is not reset; byte-enabled write at the grant edge.
  always_ff @(posedge clk_i) begin
    if (gnt_c && we_i && !addr_err_c) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) mem[word_idx][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

endmodule

// File: doc/jedro_1_mem_responder.md
Name: jedro_1_mem_responder

Overview:
- Memory-side responder for the jedro_1 core's req/gnt/rvalid bus. One instance serves the instruction port and one serves the data port, in the simulation top and in the FPGA wrapper.
- Holds a word-addressed RAM and grants requests after a configurable wait.
- Returns read data, write acknowledges and errors after a configurable latency.
- Supports at most one outstanding transaction. Sustains one transaction per cycle when GNT_WAIT=0 and RVALID_LAT=1.

Parameters:
- MEM_WORDS, 1024: RAM depth in 32-bit words; power of two.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to 4*MEM_WORDS.
- GNT_WAIT, 0: eligible req cycles before gnt_o asserts; 0..15.
- RVALID_LAT, 1: cycles from the gnt cycle to the rvalid_o cycle; 1..15.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- req_i  in  1  request; addr/we/be/wdata are stable while high until gnt.
- gnt_o  out  1  grant; the transfer happens in a cycle where req_i && gnt_o.
- rvalid_o  out  1  response valid, one cycle per granted transfer.
- we_i  in  1  1 = write, 0 = read.
- be_i  in  4  byte enables, writes only; be_i[k] enables wdata_i[8k+7:8k].
- addr_i  in  32  byte address.
- wdata_i  in  32  write data.
- rdata_o  out  32  read data, valid with rvalid_o.
- err_o  out  1  error flag, valid with rvalid_o.

Behaviour:
- Reset (synchronous, active-high): gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, wait counter=0, outstanding=0. RAM contents are not reset.
- Eligible: outstanding==0, or the response is issued (rvalid_o=1) in this cycle.
- gnt_o is combinational: gnt_o = req_i && eligible && wait_cnt==GNT_WAIT.
- Wait counter:
  - increments each cycle req_i && eligible && !gnt_o;
  - clears on grant or when req_i drops.
  - req_i dropping before gnt is a protocol violation; the block ignores it, with no side effects.
- State machine:
  - IDLE: wait for eligible req_i; go to GRANT_WAIT while wait_cnt<GNT_WAIT.
  - GRANT_WAIT: counting; go to RESP when granted.
  - RESP: latency counter runs from RVALID_LAT-1 down to 0; assert rvalid_o when it reaches 0.
    - A new grant in the same cycle restarts RESP.
    - Otherwise return to IDLE.
- Address check at grant:
  - word index = (addr_i-BASE_ADDR)>>2;
  - error if addr_i[1:0]!=0, or addr_i<BASE_ADDR, or addr_i>=BASE_ADDR+4*MEM_WORDS.
- Write at grant, no error: RAM bytes with be_i[k]=1 are updated at the grant clock edge. be_i=0 writes nothing but still responds.
- Read at grant, no error: the full word is captured into the response register at the grant edge; be_i is ignored. A read granted right after a write sees the written data.
- Error: no RAM update. Response has err_o=1 and rdata_o=0.
- Response cycle:
  - exactly RVALID_LAT cycles after the grant cycle, rvalid_o=1 for exactly one cycle;
  - reads carry the captured word, writes carry rdata_o=0, err_o as computed.
  - rdata_o=0 and err_o=0 whenever rvalid_o=0.
- Simultaneous events: rvalid_o and gnt_o may both be high in one cycle when a new request is granted back-to-back.
- Reset mid-operation:
  - any pending response is dropped, with no rvalid_o;
  - a write already granted stays in RAM;
  - a request present during reset is not granted until the cycle after rst_i falls, counted from wait_cnt=0.

Test Plan:
- rst_i high 2 cycles with req_i=1 -> gnt_o, rvalid_o, rdata_o and err_o are all 0 during reset. With GNT_WAIT=0, first gnt_o in the cycle after rst_i falls.
- GNT_WAIT=0, RVALID_LAT=1:
  - write 0xDEADBEEF to 0x10 with be=0xF, then read 0x10 back-to-back;
  - gnt cycles N and N+1, rvalid at N+1 (err=0, rdata=0) and N+2 (rdata=0xDEADBEEF).
- Byte enables: write 0x11223344 to 0x20 with be=0xF, then 0xAABBCCDD with be=0x5, then read 0x20 -> rdata=0x11BB33DD.
- GNT_WAIT=2, RVALID_LAT=3: req_i rises at cycle 0 -> gnt_o=1 only in cycle 2, rvalid_o=1 only in cycle 5.
- Errors:
  - read of BASE_ADDR+4*MEM_WORDS -> err=1, rdata=0;
  - write to 0x22 (misaligned) -> err=1 and a later read of 0x20 is unchanged.
- Reset in the cycle after a read grant with RVALID_LAT=3 -> no rvalid_o ever appears for that read. A previously granted write to 0x30 still reads back after reset.
